sia_dmac: RTL
=============

SIA_DMAC -- requirements
Module: sia_dmac

Interface
REQ-001 Parameter ADR_W, default 23, SHALL set the master halfword-address width, so m_adr_o is [ADR_W:1].
REQ-002 Parameter CNT_W, default 16, SHALL set the transfer-count width.
REQ-003 Parameter SIA_DATA_ADR, default 0, SHALL give the SIA data-register halfword address, ADR_W bits wide.
REQ-004 Port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port reset_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port rx_not_empty_i, input, 1 bit: SIA receive queue holds data.
REQ-007 Port tx_not_full_i, input, 1 bit: SIA transmit queue has space.
REQ-008 Ports rx_start_i (input, 1), rx_adr_i (input, ADR_W), rx_cnt_i (input, CNT_W): arm the RX channel (SIA to memory).
REQ-009 Ports tx_start_i (input, 1), tx_adr_i (input, ADR_W), tx_cnt_i (input, CNT_W): arm the TX channel (memory to SIA).
REQ-010 Ports rx_stop_i and tx_stop_i, input, 1 bit each: abort the channel.
REQ-011 Ports rx_busy_o, tx_busy_o, rx_done_o and tx_done_o, output, 1 bit each: channel status; done is a one-cycle pulse.
REQ-012 Pipelined Wishbone master ports: m_cyc_o, m_stb_o, m_we_o (output, 1); m_adr_o (output, ADR_W); m_sel_o (output, 2); m_dat_o (output, 16); m_dat_i (input, 16); m_ack_i and m_stall_i (input, 1).

Function
REQ-013 rx_start_i while RX is idle SHALL latch the address and count into the channel pointer and remaining count, and set rx_busy_o. The TX channel SHALL behave the same way with its own ports.
REQ-014 Start while the channel is busy SHALL be ignored. A start with count 0 SHALL pulse done the next cycle and never set busy.
REQ-015 RX is eligible when rx_busy_o and rx_not_empty_i are both 1. TX is eligible when tx_busy_o and tx_not_full_i are both 1.
REQ-016 FSM states SHALL be IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
REQ-017 In IDLE, if any channel is eligible, the FSM SHALL grant one channel and move to RD_REQ.
REQ-018 When both channels are eligible, the grant SHALL alternate round-robin, with the channel not served last winning. After reset, RX wins first.
REQ-019 RD_REQ SHALL assert m_cyc_o and m_stb_o with m_we_o=0 and m_sel_o=11. The read address SHALL be SIA_DATA_ADR for RX and the TX pointer for TX.
REQ-020 In RD_REQ, m_stb_o SHALL be held until a cycle with m_stall_i=0, then the FSM SHALL move to RD_WAIT.
REQ-021 In RD_WAIT, on m_ack_i the FSM SHALL latch m_dat_i into a 16-bit holding register and move to WR_REQ.
REQ-022 WR_REQ and WR_WAIT SHALL mirror the read phase with m_we_o=1 and m_dat_o equal to the holding register. The write address SHALL be the RX pointer for RX and SIA_DATA_ADR for TX.
REQ-023 m_cyc_o SHALL stay high from RD_REQ through the WR_WAIT ack.
REQ-024 On the write ack, the memory pointer SHALL increment by 1 (wrapping modulo 2^ADR_W), the count SHALL decrement by 1, and the FSM SHALL return to IDLE with m_cyc_o=0 for at least one cycle.
REQ-025 When the count reaches 0, the channel SHALL clear busy and pulse done for one cycle.
REQ-026 The fastest transfer SHALL take 5 cycles, from the IDLE grant to the next IDLE.
REQ-027 A stop on a channel that is not granted SHALL clear its busy at once, with no done pulse.
REQ-028 A stop on the granted channel SHALL take effect only after the current read/write pair completes; the count is decremented, then busy clears with no done pulse.
REQ-029 A stop and a start on the same channel in the same cycle: stop SHALL win.
REQ-030 Eligibility SHALL be sampled only in IDLE. Deasserting not_empty or not_full mid-pair SHALL NOT abort the pair.
REQ-031 Outside an active bus cycle, m_stb_o and m_cyc_o SHALL be 0, and m_adr_o and m_dat_o SHALL hold their last values.

Reset
REQ-032 reset_i SHALL immediately force the FSM to IDLE and clear all bus strobes, busy, done, pointers, counts, holding register and round-robin state. Every output SHALL be 0.
REQ-033 Reset during an open bus cycle SHALL drop m_cyc_o asynchronously; the in-flight word is lost.

Configuration
REQ-034 With macro SIA_DMAC_TX_EN defined, the TX channel SHALL be fully implemented.
REQ-035 Without SIA_DMAC_TX_EN, TX state logic SHALL be omitted: tx_busy_o and tx_done_o tied to 0, TX inputs ignored, arbitration always grants RX. All ports SHALL remain present.

Verification
REQ-036 RX start at 0x100, count 3, rx_not_empty_i=1, no stalls -> 3 read(SIA)/write pairs to 0x100, 0x101, 0x102, 5 cycles each, one rx_done_o pulse, rx_busy_o=0.
REQ-037 Both channels busy and eligible, count 2 each -> grant order RX, TX, RX, TX.
REQ-038 m_stall_i=1 for 3 cycles during RD_REQ -> m_stb_o held 4 cycles, address stable, data written correctly.
REQ-039 tx_stop_i asserted in WR_WAIT -> pair completes, count 4 becomes 3, tx_busy_o=0, no tx_done_o.
REQ-040 reset_i asserted in RD_WAIT -> m_cyc_o=0 the same cycle, all outputs 0; a later rx_start_i works normally.
REQ-041 Build without SIA_DMAC_TX_EN, tx_start_i pulsed -> tx_busy_o stays 0, no bus traffic.

Source files
------------

// File: rtl/sia_dmac.sv
// sia_dmac: two-channel DMA between the SIA data register and memory over a pipelined
// Wishbone master. The TX channel is built only when SIA_DMAC_TX_EN is defined.
module sia_dmac #(
   parameter int unsigned      ADR_W        = 23,
   parameter int unsigned      CNT_W        = 16,
   parameter logic [ADR_W-1:0] SIA_DATA_ADR = '0
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             rx_not_empty_i,
   input  logic             tx_not_full_i,
   input  logic             rx_start_i,
   input  logic [ADR_W:1]   rx_adr_i,
   input  logic [CNT_W-1:0] rx_cnt_i,
   input  logic             tx_start_i,
   input  logic [ADR_W:1]   tx_adr_i,
   input  logic [CNT_W-1:0] tx_cnt_i,
   input  logic             rx_stop_i,
   input  logic             tx_stop_i,
   output logic             rx_busy_o,
   output logic             tx_busy_o,
   output logic             rx_done_o,
   output logic             tx_done_o,
   output logic             m_cyc_o,
   output logic             m_stb_o,
   output logic             m_we_o,
   output logic [ADR_W:1]   m_adr_o,
   output logic [1:0]       m_sel_o,
   output logic [15:0]      m_dat_o,
   input  logic [15:0]      m_dat_i,
   input  logic             m_ack_i,
   input  logic             m_stall_i
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] RD_REQ  = 3'd1;
   localparam logic [2:0] RD_WAIT = 3'd2;
   localparam logic [2:0] WR_REQ  = 3'd3;
   localparam logic [2:0] WR_WAIT = 3'd4;

   logic [2:0]       state_q;
   logic             gnt_q;      // 0 = RX, 1 = TX
   logic [ADR_W:1]   adr_q;
   logic [15:0]      hold_q;

   logic             rx_busy_q, rx_done_q, rx_pend_q;
   logic [ADR_W:1]   rx_ptr_q;
   logic [CNT_W-1:0] rx_cnt_q;
   logic             tx_busy_q, tx_done_q, tx_pend_q;
   logic [ADR_W:1]   tx_ptr_q;
   logic [CNT_W-1:0] tx_cnt_q;
   logic             rr_q;       // 1 = TX preferred on the next contended grant

   logic rx_elig, tx_elig, gnt_nxt, wr_ack;
   logic rx_fin, tx_fin, rx_inflight, tx_inflight, rx_abort, tx_abort;

   // A stop in the same cycle masks eligibility so a stopped channel is never granted.
   assign rx_elig     = rx_busy_q & rx_not_empty_i & ~rx_stop_i;
   assign tx_elig     = tx_busy_q & tx_not_full_i & ~tx_stop_i;
   assign gnt_nxt     = tx_elig & (~rx_elig | rr_q);
   assign wr_ack      = (state_q == WR_WAIT) & m_ack_i;
   assign rx_fin      = wr_ack & ~gnt_q;
   assign tx_fin      = wr_ack & gnt_q;
   assign rx_inflight = (state_q != IDLE) & ~gnt_q;
   assign tx_inflight = (state_q != IDLE) & gnt_q;
   assign rx_abort    = rx_stop_i | rx_pend_q;
   assign tx_abort    = tx_stop_i | tx_pend_q;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         gnt_q   <= 1'b0;
         adr_q   <= '0;
         hold_q  <= '0;
      end else begin
         case (state_q)
            IDLE: if (rx_elig | tx_elig) begin
               gnt_q   <= gnt_nxt;
               adr_q   <= gnt_nxt ? tx_ptr_q : SIA_DATA_ADR;
               state_q <= RD_REQ;
            end
            RD_REQ: if (!m_stall_i) state_q <= RD_WAIT;
            RD_WAIT: if (m_ack_i) begin
               hold_q  <= m_dat_i;
               adr_q   <= gnt_q ? SIA_DATA_ADR : rx_ptr_q;
               state_q <= WR_REQ;
            end
            WR_REQ: if (!m_stall_i) state_q <= WR_WAIT;
            WR_WAIT: if (m_ack_i) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // A stop on the granted channel is parked until the write ack closes the pair.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rx_busy_q <= 1'b0;
         rx_done_q <= 1'b0;
         rx_pend_q <= 1'b0;
         rx_ptr_q  <= '0;
         rx_cnt_q  <= '0;
      end else begin
         rx_done_q <= 1'b0;
         if (rx_fin) begin
            rx_ptr_q  <= rx_ptr_q + ADR_W'(1);
            rx_cnt_q  <= rx_cnt_q - CNT_W'(1);
            rx_pend_q <= 1'b0;
            if (rx_abort || rx_cnt_q == CNT_W'(1)) rx_busy_q <= 1'b0;
            rx_done_q <= ~rx_abort & (rx_cnt_q == CNT_W'(1));
         end else if (rx_stop_i) begin
            if (rx_inflight) rx_pend_q <= 1'b1;
            else             rx_busy_q <= 1'b0;
         end else if (rx_start_i && !rx_busy_q) begin
            if (rx_cnt_i == '0) begin
               rx_done_q <= 1'b1;
            end else begin
               rx_busy_q <= 1'b1;
               rx_ptr_q  <= rx_adr_i;
               rx_cnt_q  <= rx_cnt_i;
            end
         end
      end
   end

`ifdef SIA_DMAC_TX_EN
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         tx_busy_q <= 1'b0;
         tx_done_q <= 1'b0;
         tx_pend_q <= 1'b0;
         tx_ptr_q  <= '0;
         tx_cnt_q  <= '0;
         rr_q      <= 1'b0;
      end else begin
         tx_done_q <= 1'b0;
         if (state_q == IDLE && (rx_elig || tx_elig)) rr_q <= ~gnt_nxt;
         if (tx_fin) begin
            tx_ptr_q  <= tx_ptr_q + ADR_W'(1);
            tx_cnt_q  <= tx_cnt_q - CNT_W'(1);
            tx_pend_q <= 1'b0;
            if (tx_abort || tx_cnt_q == CNT_W'(1)) tx_busy_q <= 1'b0;
            tx_done_q <= ~tx_abort & (tx_cnt_q == CNT_W'(1));
         end else if (tx_stop_i) begin
            if (tx_inflight) tx_pend_q <= 1'b1;
            else             tx_busy_q <= 1'b0;
         end else if (tx_start_i && !tx_busy_q) begin
            if (tx_cnt_i == '0) begin
               tx_done_q <= 1'b1;
            end else begin
               tx_busy_q <= 1'b1;
               tx_ptr_q  <= tx_adr_i;
               tx_cnt_q  <= tx_cnt_i;
            end
         end
      end
   end
`else
   logic unused_tx;
   assign unused_tx = ^{tx_start_i, tx_adr_i, tx_cnt_i, tx_fin, tx_inflight, tx_abort};
   assign tx_busy_q = 1'b0;
   assign tx_done_q = 1'b0;
   assign tx_pend_q = 1'b0;
   assign tx_ptr_q  = '0;
   assign tx_cnt_q  = '0;
   assign rr_q      = 1'b0;
`endif

   assign rx_busy_o = rx_busy_q;
   assign rx_done_o = rx_done_q;
   assign tx_busy_o = tx_busy_q;
   assign tx_done_o = tx_done_q;
   assign m_cyc_o   = (state_q != IDLE);
   assign m_stb_o   = (state_q == RD_REQ) | (state_q == WR_REQ);
   assign m_we_o    = (state_q == WR_REQ) | (state_q == WR_WAIT);
   assign m_sel_o   = {2{m_cyc_o}};
   assign m_adr_o   = adr_q;
   assign m_dat_o   = hold_q;

endmodule
